masku_result_shuffler: RTL and testbench

Write-back side of the mask unit: collects compressed mask-result chunks produced by MASKU execution in sequential (deshuffled) bit order, packs them into a datapath-wide buffer, reshuffles the bytes into the lane layout for the destination EEW, and hands one ELEN word per lane to the lanes with independent per-lane valid/ready handshakes. It is the inverse of MASKU operand intake: lane layout goes out, sequential layout comes in.

---
 rtl/ara_pkg.sv | 35 +++
 rtl/masku_result_shuffler.sv | 155 +++++++++++++++
 tb/tb_masku_result_shuffler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ara_pkg.sv
// Shared vector-unit types: element widths, lane byte shuffling and the
// mask-unit write-back state encoding.
package ara_pkg;
    localparam int unsigned ELEN  = 64;
    localparam int unsigned ELENB = ELEN / 8;

    typedef logic [ELEN-1:0] elen_t;

    typedef enum logic [1:0] {
        EW8  = 2'd0,
        EW16 = 2'd1,
        EW32 = 2'd2,
        EW64 = 2'd3
    } vew_e;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } masku_wb_state_e;

    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Element e goes to lane e % nr_lanes; lane-local bytes are interleaved
    // ELENB at a time across the lanes.
    function automatic int unsigned shuffle_index(int unsigned b, int unsigned nr_lanes, vew_e ew);
        int unsigned eb, elem, lane, lane_off;
        eb       = 1 << int'(ew);
        elem     = b >> int'(ew);
        lane     = elem % nr_lanes;
        lane_off = (elem / nr_lanes) * eb + (b & (eb - 1));
        return (lane_off / ELENB) * ELENB * nr_lanes + ELENB * lane + (lane_off % ELENB);
    endfunction
endpackage

// File: rtl/masku_result_shuffler.sv
// Packs sequential mask-result chunks into a DW-wide word, reshuffles it into
// lane layout for the destination EEW and hands one ELEN word to each lane.
module masku_result_shuffler
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes      = 0,
    parameter int unsigned WordIdxWidth = 16,
    // NrLanes must be set by the parent; NL only keeps elaboration legal at the default.
    localparam int unsigned NL  = (NrLanes == 0) ? 1 : NrLanes,
    localparam int unsigned DW  = NL * ELEN,
    localparam int unsigned CBW = idx_width(DW) + 1,
    localparam int unsigned BIW = idx_width(DW / 8)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  vew_e                         eew_i,
    input  logic [DW-1:0]                chunk_i,
    input  logic [CBW-1:0]               chunk_bits_i,
    input  logic                         chunk_last_i,
    input  logic                         chunk_valid_i,
    output logic                         chunk_ready_o,
    output elen_t [NL-1:0]               result_o,
    output logic [NL-1:0][ELENB-1:0]     result_be_o,
    output logic [WordIdxWidth-1:0]      result_word_idx_o,
    output logic [NL-1:0]                result_valid_o,
    input  logic [NL-1:0]                result_ready_i,
    output logic                         done_o
);
    masku_wb_state_e         state_q;
    logic [DW-1:0]           buf_q;
    logic [CBW-1:0]          fill_q;
    logic [WordIdxWidth-1:0] word_idx_q;
    logic                    last_q;
    vew_e                    eew_q;
    logic [NL-1:0]           pending_q;
    logic                    done_q;
    elen_t [NL-1:0]          result_q;
    logic [NL-1:0][ELENB-1:0] be_q;

    logic                    accept, overflow, completes;
    logic [CBW-1:0]          cb_eff, fill_next;
    logic [CBW:0]            fill_sum;
    logic [DW-1:0]           chunk_mask, buf_next, shuf_data;
    logic [DW/8-1:0]         shuf_be;
    logic [NL-1:0]           pend_lanes, pend_next;
    vew_e                    eew_sel;
    logic [BIW-1:0]          d;
    logic [7:0]              byte_v;
    int unsigned             nbytes, fill_n;

    assign chunk_ready_o = (state_q == FILL) && !rst_i;
    assign accept        = chunk_ready_o && chunk_valid_i;

    assign cb_eff     = (chunk_bits_i > CBW'(DW)) ? CBW'(DW) : chunk_bits_i;
    assign fill_sum   = {1'b0, fill_q} + {1'b0, cb_eff};
    assign overflow   = fill_sum > (CBW + 1)'(DW);
    assign fill_next  = overflow ? CBW'(DW) : fill_sum[CBW-1:0];
    assign chunk_mask = {DW{1'b1}} >> (DW - 32'(cb_eff));
    // Bits shifted past DW fall off: that is the overflow drop.
    assign buf_next   = buf_q | ((chunk_i & chunk_mask) << fill_q);
    assign eew_sel    = (fill_q == '0 && word_idx_q == '0) ? eew_i : eew_q;
    assign completes  = accept && (fill_next == CBW'(DW) || chunk_last_i);
    assign pend_next  = pending_q & ~result_ready_i;

    always_comb begin
        shuf_data = '0;
        shuf_be   = '0;
        d         = '0;
        byte_v    = '0;
        fill_n    = 32'(fill_next);
        nbytes    = (fill_n + 7) >> 3;
        for (int b = 0; b < DW / 8; b++) begin
            d      = BIW'(shuffle_index(b, NL, eew_sel));
            byte_v = buf_next[8*b +: 8];
            if (b < nbytes) begin
                // Tail-agnostic: partially filled bytes are padded with ones.
                for (int k = 0; k < 8; k++)
                    if (8 * b + k >= fill_n) byte_v[k] = 1'b1;
                shuf_be[d] = 1'b1;
            end
            shuf_data[{d, 3'b000} +: 8] = byte_v;
        end
    end

    always_comb begin
        pend_lanes = '0;
        for (int l = 0; l < NL; l++) pend_lanes[l] = |shuf_be[l*ELENB +: ELENB];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FILL;
            buf_q      <= '0;
            fill_q     <= '0;
            word_idx_q <= '0;
            last_q     <= 1'b0;
            eew_q      <= EW8;
            pending_q  <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            be_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q    <= FILL;
                buf_q      <= '0;
                fill_q     <= '0;
                word_idx_q <= '0;
                last_q     <= 1'b0;
                pending_q  <= '0;
            end else begin
                unique case (state_q)
                    FILL: if (accept) begin
                        buf_q  <= buf_next;
                        fill_q <= fill_next;
                        if (fill_q == '0 && word_idx_q == '0) eew_q <= eew_i;
                        if (completes) begin
                            state_q   <= DRAIN;
                            last_q    <= chunk_last_i;
                            result_q  <= shuf_data;
                            be_q      <= shuf_be;
                            pending_q <= pend_lanes;
                        end
                    end
                    DRAIN: begin
                        pending_q <= pend_next;
                        if (pend_next == '0) begin
                            state_q    <= FILL;
                            buf_q      <= '0;
                            fill_q     <= '0;
                            last_q     <= 1'b0;
                            done_q     <= last_q;
                            word_idx_q <= last_q ? '0 : word_idx_q + 1'b1;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (NrLanes inside {1, 2, 4, 8, 16});
            if (!flush_i && accept) assert (!overflow);
        end
    end

    assign result_o          = result_q;
    assign result_be_o       = be_q;
    assign result_word_idx_o = word_idx_q;
    assign result_valid_o    = pending_q;
    assign done_o            = done_q;
endmodule

// File: tb/tb_masku_result_shuffler.sv
// Directed bench for masku_result_shuffler with 4 lanes (DW = 256).
module tb_masku_result_shuffler;
    import ara_pkg::*;

    logic              clk = 1'b0;
    logic              rst, flush;
    vew_e              eew;
    logic [255:0]      chunk;
    logic [8:0]        chunk_bits;
    logic              last, cvalid, cready;
    elen_t [3:0]       result;
    logic [3:0][7:0]   be;
    logic [15:0]       widx;
    logic [3:0]        rvalid, rready;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    masku_result_shuffler #(.NrLanes(4), .WordIdxWidth(16)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .eew_i(eew),
        .chunk_i(chunk), .chunk_bits_i(chunk_bits), .chunk_last_i(last),
        .chunk_valid_i(cvalid), .chunk_ready_o(cready),
        .result_o(result), .result_be_o(be), .result_word_idx_o(widx),
        .result_valid_o(rvalid), .result_ready_i(rready), .done_o(done)
    );

    // Called at a negedge; the chunk is presented for exactly one rising edge.
    task automatic put_chunk(input logic [255:0] dat, input int bits, input logic l, input vew_e e);
        chunk = dat; chunk_bits = 9'(bits); last = l; eew = e; cvalid = 1'b1;
        @(negedge clk);
        cvalid = 1'b0; chunk = '0; last = 1'b0;
    endtask

    function automatic logic [255:0] byte_ramp(input logic [7:0] base);
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[8*k +: 8] = base + 8'(k);
        return v;
    endfunction

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; cvalid = 1'b0; rready = '0;
        chunk = '0; chunk_bits = '0; last = 1'b0; eew = EW8;
        repeat (2) @(negedge clk);
        n_tests++; if (cready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", cready); end
        n_tests++; if (rvalid !== 4'h0 || done !== 1'b0 || widx !== 16'h0) begin
            n_fail++; $display("FAIL reset_ctrl got valid=%h done=%b idx=%0d want 0/0/0", rvalid, done, widx); end
        n_tests++; if (result !== '0 || be !== '0) begin
            n_fail++; $display("FAIL reset_data got result=%h be=%h want 0", result, be); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (cready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", cready); end
    endtask

    task automatic test_ew64_full;
        elen_t exp;
        n_tests++; if (cready !== 1'b1) begin n_fail++; $display("FAIL ew64_ready_pre got %b want 1", cready); end
        put_chunk(byte_ramp(8'h00), 256, 1'b1, EW64);
        n_tests++; if (rvalid !== 4'hF || cready !== 1'b0) begin
            n_fail++; $display("FAIL ew64_valid got valid=%h ready=%b want f/0", rvalid, cready); end
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 8; i++) exp[8*i +: 8] = 8'(8 * l + i);
            n_tests++; if (result[l] !== exp || be[l] !== 8'hFF) begin
                n_fail++; $display("FAIL ew64_lane%0d got %h be=%h want %h be=ff", l, result[l], be[l], exp); end
        end
        n_tests++; if (widx !== 16'd0) begin n_fail++; $display("FAIL ew64_idx got %0d want 0", widx); end
        rready = 4'hF;
        @(negedge clk);
        n_tests++; if (rvalid !== 4'h0 || done !== 1'b1 || cready !== 1'b1) begin
            n_fail++; $display("FAIL ew64_done got valid=%h done=%b ready=%b want 0/1/1", rvalid, done, cready); end
        rready = 4'h0;
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ew64_done_pulse got %b want 0", done); end
    endtask

    task automatic test_ew64_partial;
        elen_t p [3];
        p[0] = 64'hA0A1_A2A3_A4A5_A6A7;
        p[1] = 64'hB0B1_B2B3_B4B5_B6B7;
        p[2] = 64'hC0C1_C2C3_C4C5_C6C7;
        // Upper bits are garbage that must be masked; later EEW values must be ignored.
        put_chunk({{192{1'b1}}, p[0]}, 64, 1'b0, EW64);
        put_chunk({{192{1'b1}}, p[1]}, 64, 1'b0, EW8);
        n_tests++; if (rvalid !== 4'h0 || cready !== 1'b1) begin
            n_fail++; $display("FAIL partial_midfill got valid=%h ready=%b want 0/1", rvalid, cready); end
        put_chunk({{192{1'b1}}, p[2]}, 64, 1'b1, EW8);
        n_tests++; if (rvalid !== 4'b0111) begin n_fail++; $display("FAIL partial_valid got %b want 0111", rvalid); end
        for (int l = 0; l < 3; l++) begin
            n_tests++; if (result[l] !== p[l] || be[l] !== 8'hFF) begin
                n_fail++; $display("FAIL partial_lane%0d got %h be=%h want %h be=ff", l, result[l], be[l], p[l]); end
        end
        n_tests++; if (be[3] !== 8'h00) begin n_fail++; $display("FAIL partial_be3 got %h want 00", be[3]); end
        rready = 4'hF;
        @(negedge clk);
        n_tests++; if (rvalid !== 4'h0 || done !== 1'b1) begin
            n_fail++; $display("FAIL partial_done got valid=%h done=%b want 0/1", rvalid, done); end
        rready = 4'h0;
    endtask

    task automatic test_ew8_shuffle;
        logic [255:0] exp, got;
        for (int k = 0; k < 32; k++) exp[8 * (8 * (k % 4) + k / 4) +: 8] = 8'(k);
        put_chunk(byte_ramp(8'h00), 256, 1'b1, EW8);
        got = result;
        n_tests++; if (got !== exp || be !== {4{8'hFF}}) begin
            n_fail++; $display("FAIL ew8_shuffle got %h be=%h want %h", got, be, exp); end
        rready = 4'hF;
        @(negedge clk);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ew8_done got %b want 1", done); end
        rready = 4'h0;
    endtask

    task automatic test_backpressure;
        put_chunk(byte_ramp(8'h10), 256, 1'b1, EW64);
        n_tests++; if (rvalid !== 4'hF) begin n_fail++; $display("FAIL bp_valid got %h want f", rvalid); end
        rready = 4'b1011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++; if (rvalid !== 4'b0100 || cready !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold%0d got valid=%b ready=%b done=%b want 0100/0/0", c, rvalid, cready, done); end
        end
        rready = 4'hF;
        @(negedge clk);
        n_tests++; if (rvalid !== 4'h0 || cready !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got valid=%h ready=%b done=%b want 0/1/1", rvalid, cready, done); end
        rready = 4'h0;
    endtask

    function automatic elen_t tag(input int c, input int h);
        return 64'hD000_0000_0000_0000 + 64'(2 * c + h);
    endfunction

    task automatic test_multi_word;
        logic [3:0] exp_v;
        for (int w = 0; w < 3; w++) begin
            put_chunk({128'h0, tag(2 * w, 1), tag(2 * w, 0)}, 128, w == 2, (w == 0) ? EW64 : EW8);
            if (w < 2) put_chunk({128'h0, tag(2 * w + 1, 1), tag(2 * w + 1, 0)}, 128, 1'b0, EW8);
            exp_v = (w < 2) ? 4'hF : 4'h3;
            n_tests++; if (rvalid !== exp_v || widx !== 16'(w)) begin
                n_fail++; $display("FAIL multi_w%0d got valid=%h idx=%0d want %h/%0d", w, rvalid, widx, exp_v, w); end
            for (int l = 0; l < 4; l++) begin
                if (exp_v[l]) begin
                    n_tests++; if (result[l] !== tag(2 * w + l / 2, l % 2) || be[l] !== 8'hFF) begin
                        n_fail++; $display("FAIL multi_w%0d_lane%0d got %h be=%h want %h be=ff",
                                           w, l, result[l], be[l], tag(2 * w + l / 2, l % 2)); end
                end else begin
                    n_tests++; if (be[l] !== 8'h00) begin
                        n_fail++; $display("FAIL multi_w%0d_be%0d got %h want 00", w, l, be[l]); end
                end
            end
            rready = 4'hF;
            @(negedge clk);
            rready = 4'h0;
            n_tests++; if (done !== (w == 2) || cready !== 1'b1 || rvalid !== 4'h0) begin
                n_fail++; $display("FAIL multi_w%0d_end got done=%b ready=%b valid=%h want %b/1/0", w, done, cready, rvalid, w == 2); end
        end
    endtask

    task automatic test_flush;
        put_chunk(byte_ramp(8'h00), 256, 1'b0, EW64);
        rready = 4'hF;
        @(negedge clk);
        rready = 4'h0;
        n_tests++; if (widx !== 16'd1 || done !== 1'b0) begin
            n_fail++; $display("FAIL flush_pre got idx=%0d done=%b want 1/0", widx, done); end
        put_chunk(byte_ramp(8'h20), 256, 1'b0, EW64);
        n_tests++; if (rvalid !== 4'hF || widx !== 16'd1) begin
            n_fail++; $display("FAIL flush_drain got valid=%h idx=%0d want f/1", rvalid, widx); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (rvalid !== 4'h0 || cready !== 1'b1 || widx !== 16'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL flush_state got valid=%h ready=%b idx=%0d done=%b want 0/1/0/0", rvalid, cready, widx, done); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_nodone got %b want 0", done); end
        // A zero chunk must come out as zero if the flushed buffer was cleared.
        put_chunk('0, 256, 1'b1, EW64);
        n_tests++; if (result !== '0 || be !== {4{8'hFF}} || widx !== 16'd0) begin
            n_fail++; $display("FAIL flush_clean got %h be=%h idx=%0d want 0/ff../0", result, be, widx); end
        rready = 4'hF;
        @(negedge clk);
        rready = 4'h0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL flush_clean_done got %b want 1", done); end
    endtask

    task automatic test_reset_drain;
        put_chunk(byte_ramp(8'h40), 256, 1'b0, EW64);
        rready = 4'hF;
        @(negedge clk);
        rready = 4'h0;
        put_chunk(byte_ramp(8'h60), 256, 1'b0, EW64);
        n_tests++; if (rvalid !== 4'hF || widx !== 16'd1) begin
            n_fail++; $display("FAIL rstd_drain got valid=%h idx=%0d want f/1", rvalid, widx); end
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (rvalid !== 4'h0 || cready !== 1'b0 || widx !== 16'd0 || done !== 1'b0 ||
                       result !== '0 || be !== '0) begin
            n_fail++; $display("FAIL rstd_state got valid=%h ready=%b idx=%0d done=%b want 0/0/0/0", rvalid, cready, widx, done); end
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (cready !== 1'b1 || rvalid !== 4'h0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rstd_release got ready=%b valid=%h done=%b want 1/0/0", cready, rvalid, done); end
    endtask

    initial begin
        test_reset();
        test_ew64_full();
        test_ew64_partial();
        test_ew8_shuffle();
        test_backpressure();
        test_multi_word();
        test_flush();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
